// File: rtl/scalar_regfile_sb.sv
// Scalar register file for the ASIP pipeline: combinational read ports with
// write bypass, per-register pending-write scoreboard, and a sequential
// bulk-clear engine used on kernel restart.
module scalar_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 16,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              we,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              clr_req,
  output logic              clr_busy
);

  localparam int CNT_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              pend [DEPTH];
  logic [DEPTH-1:0]  pend_vec;
  logic [DEPTH-1:0]  hit1, hit2, hit_wr, hit_iss, hit_clr;
  logic [DATA_W-1:0] or1 [DEPTH+1];
  logic [DATA_W-1:0] or2 [DEPTH+1];

  logic wr_eff, iss_eff, ok1, ok2, byp1, byp2;

  // An address names a real register: in range and not the hardwired zero.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    addr_ok = ({1'b0, a} < DEPTH_X) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_eff  = we && addr_ok(rd_addr) && (state == IDLE);
  assign iss_eff = issue_en && addr_ok(issue_rd) && (state == IDLE);
  assign ok1     = addr_ok(rs1_addr);
  assign ok2     = addr_ok(rs2_addr);
  assign byp1    = (BYPASS != 0) && wr_eff && (rd_addr == rs1_addr);
  assign byp2    = (BYPASS != 0) && wr_eff && (rd_addr == rs2_addr);

  assign or1[0] = '0;
  assign or2[0] = '0;

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    assign hit1[i]    = (rs1_addr == ADDR_W'(i));
    assign hit2[i]    = (rs2_addr == ADDR_W'(i));
    assign hit_wr[i]  = wr_eff  && (rd_addr  == ADDR_W'(i));
    assign hit_iss[i] = iss_eff && (issue_rd == ADDR_W'(i));
    assign hit_clr[i] = (state == CLEAR) && (cnt == CNT_W'(i));
    assign pend_vec[i] = pend[i];
    assign or1[i+1] = or1[i] | (hit1[i] ? regs[i] : '0);
    assign or2[i+1] = or2[i] | (hit2[i] ? regs[i] : '0);

    // Per-register data and pending bit; a same-cycle issue beats the write
    // because the newer instruction is still outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        regs[i] <= '0;
        pend[i] <= 1'b0;
      end else if (hit_clr[i]) begin
        regs[i] <= '0;
        pend[i] <= 1'b0;
      end else begin
        if (hit_wr[i])       regs[i] <= wdata;
        if (hit_iss[i])      pend[i] <= 1'b1;
        else if (hit_wr[i])  pend[i] <= 1'b0;
      end
    end
  end

  // Read ports: zero for invalid addresses, bypass a same-cycle write.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (ok1) rs1_data = byp1 ? wdata : or1[DEPTH];
    if (ok2) rs2_data = byp2 ? wdata : or2[DEPTH];
  end

  // Hazard flags; forced during a clear so decode stalls.
  always_comb begin
    rs1_busy = ok1 && ((hit1 & pend_vec) != '0) && !byp1;
    rs2_busy = ok2 && ((hit2 & pend_vec) != '0) && !byp2;
    if (state == CLEAR) begin
      rs1_busy = 1'b1;
      rs2_busy = 1'b1;
    end
  end

  // Clear FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Clear FSM next state: one pass over every register, no restart.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_req) state_nxt = CLEAR;
      CLEAR:   if (cnt == CNT_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Clear FSM outputs.
  always_comb begin
    clr_busy = (state == CLEAR);
  end

  // Clear sweep counter; held at 0 while idle so a new clear starts at r0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (state == IDLE)     cnt <= '0;
    else if (cnt == CNT_LAST)   cnt <= '0;
    else                        cnt <= cnt + 1'b1;
  end

endmodule

// File: tb/tb_scalar_regfile_sb.sv
// Directed bench for scalar_regfile_sb: the driver pushes hand-computed
// expectations into a queue, a negedge monitor pops and compares them.
module tb_scalar_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rs1_addr = '0, rs2_addr = '0, rd_addr = '0, issue_rd = '0;
  logic [31:0] rs1_data, rs2_data, wdata = '0;
  logic        rs1_busy, rs2_busy, clr_busy;
  logic        we = 1'b0, issue_en = 1'b0, clr_req = 1'b0;

  typedef struct {
    string       name;
    logic [31:0] d1, d2;
    logic        b1, b2, cb;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  scalar_regfile_sb dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .we(we), .rd_addr(rd_addr), .wdata(wdata),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

  // Monitor: one expectation per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_tests++;
      if (rs1_data !== e.d1 || rs2_data !== e.d2 || rs1_busy !== e.b1 ||
          rs2_busy !== e.b2 || clr_busy !== e.cb) begin
        n_fail++;
        $display("FAIL %s: got d1=%h d2=%h b1=%b b2=%b cb=%b, want d1=%h d2=%h b1=%b b2=%b cb=%b",
                 e.name, rs1_data, rs2_data, rs1_busy, rs2_busy, clr_busy,
                 e.d1, e.d2, e.b1, e.b2, e.cb);
      end
    end
  end

  task automatic drive(input logic w, input logic [4:0] rd, input logic [31:0] wd,
                       input logic ie, input logic [4:0] ird, input logic cr,
                       input logic [4:0] a1, input logic [4:0] a2);
    @(posedge clk); #1;
    we = w; rd_addr = rd; wdata = wd;
    issue_en = ie; issue_rd = ird; clr_req = cr;
    rs1_addr = a1; rs2_addr = a2;
  endtask

  task automatic expect_out(input string n, input logic [31:0] d1, input logic [31:0] d2,
                            input logic b1, input logic b2, input logic cb);
    exp_t e;
    e.name = n; e.d1 = d1; e.d2 = d2; e.b1 = b1; e.b2 = b2; e.cb = cb;
    exp_q.push_back(e);
  endtask

  initial begin
    logic [31:0] v1, v2;
    // 1: reset
    drive(0, 0, 0, 0, 0, 0, 5, 3);
    expect_out("rst_low", 0, 0, 0, 0, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    for (int a = 0; a < 16; a++) begin
      drive(0, 0, 0, 0, 0, 0, 5'(a), 5'(15 - a));
      expect_out("rst_read", 0, 0, 0, 0, 0);
    end
    // 2: write and invalid writes
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 9, 9);
    drive(0, 0, 0, 0, 0, 0, 5, 0);
    expect_out("wr_r5", 32'hDEADBEEF, 0, 0, 0, 0);
    drive(1, 0, 32'h1234, 0, 0, 0, 0, 0);
    expect_out("wr_r0_nobyp", 0, 0, 0, 0, 0);
    drive(1, 20, 32'h1234, 0, 0, 0, 20, 5);
    expect_out("wr_r20_nobyp", 0, 32'hDEADBEEF, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 20);
    expect_out("r0_r20_after", 0, 0, 0, 0, 0);
    // 3: bypass
    drive(1, 7, 32'hA5A5A5A5, 0, 0, 0, 5, 7);
    expect_out("bypass_r7", 32'hDEADBEEF, 32'hA5A5A5A5, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 7, 7);
    expect_out("r7_stored", 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 0);
    // 4: scoreboard
    drive(0, 0, 0, 1, 3, 0, 3, 3);
    expect_out("issue_cycle", 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 3, 5);
    expect_out("r3_busy", 0, 32'hDEADBEEF, 1, 0, 0);
    drive(1, 3, 32'h33, 0, 0, 0, 3, 3);
    expect_out("wb_bypass_free", 32'h33, 32'h33, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 3, 3);
    expect_out("r3_free", 32'h33, 32'h33, 0, 0, 0);
    drive(0, 0, 0, 1, 3, 0, 3, 3);
    expect_out("reissue_r3", 32'h33, 32'h33, 0, 0, 0);
    drive(1, 3, 32'h44, 1, 3, 0, 3, 3);
    expect_out("iss_wr_same", 32'h44, 32'h44, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 3, 3);
    expect_out("set_wins", 32'h44, 32'h44, 1, 1, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 20);
    drive(0, 0, 0, 1, 20, 0, 0, 20);
    drive(0, 0, 0, 0, 0, 0, 0, 20);
    expect_out("issue_invalid", 0, 0, 0, 0, 0);
    // 5: fill, then bulk clear
    for (int i = 1; i < 16; i++) drive(1, 5'(i), 32'h100 + i, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 9, 0, 9, 1);
    drive(0, 0, 0, 0, 0, 0, 9, 1);
    expect_out("pre_clear", 32'h109, 32'h101, 1, 0, 0);
    drive(1, 2, 32'h222, 0, 0, 1, 2, 9);
    expect_out("clr_req_cycle", 32'h222, 32'h109, 0, 1, 0);
    for (int k = 0; k < 16; k++) begin
      drive(1, 15, 32'hBAD, 1, 14, 1, 5'(k), 5'((k + 15) % 16));
      v1 = (k == 0) ? 32'h0 : (k == 2) ? 32'h222 : 32'h100 + k;
      v2 = (k == 0) ? 32'h10F : 32'h0;
      expect_out("clearing", v1, v2, 1, 1, 1);
    end
    for (int a = 0; a < 16; a++) begin
      drive(0, 0, 0, 0, 0, 0, 5'(a), 5'(a));
      expect_out("after_clear", 0, 0, 0, 0, 0);
    end
    // 6: reset during a clear
    drive(1, 10, 32'h55, 0, 0, 0, 10, 10);
    drive(0, 0, 0, 0, 0, 1, 10, 10);
    expect_out("clr6_req", 32'h55, 32'h55, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 0, 0, 0, 0, 10, 10);
      expect_out("clr6_run", 32'h55, 32'h55, 1, 1, 1);
    end
    @(posedge clk); #1; rst_n = 1'b0;
    expect_out("rst_mid_clear", 0, 0, 0, 0, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 10, 10);
    expect_out("reclr_req", 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 10, 10);
    expect_out("reclr_started", 0, 0, 1, 1, 1);
    for (int k = 0; k < 15; k++) drive(0, 0, 0, 0, 0, 0, 10, 10);
    drive(0, 0, 0, 0, 0, 0, 10, 10);
    expect_out("reclr_done", 0, 0, 0, 0, 0);
    // drain the scoreboard, bounded
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
